decode_stage_p: RTL and testbench

- Parametrised successor to the single-issue RV32I decode stage.
- Decodes one instruction per cycle into a registered ID/EX payload with valid/ready handshakes on both sides.
- Owns the integer register file, with write-through bypass from writeback, refresh of held operands while stalled, flush, and a counted load-use bubble.
- Sits between fetch and the ALU/execute stage.

---
 rtl/decode_pkg.sv | 33 +++
 rtl/decode_stage_p_regfile.sv | 52 +++++
 rtl/decode_stage_p.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_stage_p.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate
// formats and the ID/EX control bundle.
package decode_pkg;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP = 7'b0010011;
  localparam logic [6:0] I_TYPE_LD = 7'b0000011;
  localparam logic [6:0] U_TYPE    = 7'b0110111;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] J_TYPE    = 7'b1101111;
  localparam logic [6:0] S_TYPE    = 7'b0100011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  // Width-independent part of the ID/EX payload.
  typedef struct packed {
    logic [6:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
  } id_ex_payload_t;

endpackage

// File: rtl/decode_stage_p_regfile.sv
// Integer register file: two async reads, one
// sync write, x0 hardwired, optional WB bypass.
module regfile_2r1w #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata
);

  localparam int RW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic [XLEN-1:0] rd_port(
    input logic [RW-1:0] a
  );
    logic [XLEN-1:0] v;
    if (a == '0)
      v = '0;
    else if (WB_BYPASS != 0 && we && a == waddr)
      v = wdata;
    else
      v = regs[a];
    return v;
  endfunction

  // Read ports, x0 forced to zero, optional bypass.
  always_comb begin
    rdata1 = rd_port(raddr1);
    rdata2 = rd_port(raddr2);
  end

  // Synchronous clear and write; x0 never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/decode_stage_p.sv
// RV32I/E decode stage: registered ID/EX payload,
// WB bypass, held-operand refresh, load-use bubbles.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int NREGS            = 32,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int WB_BYPASS        = 1
) (
  input  logic                     req,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr_in,
  input  logic [XLEN-1:0]          pc_in_dec,
  input  logic                     flush,
  input  logic [$clog2(NREGS)-1:0] rd_in,
  input  logic                     rd_write_in,
  input  logic [XLEN-1:0]          rd_value_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [XLEN-1:0]          pc_out_dec,
  output logic [2:0]               funct3_out,
  output logic [6:0]               funct7_out,
  output logic [6:0]               alu_op_out,
  output logic [$clog2(NREGS)-1:0] rd_out,
  output logic                     rd_write_out,
  output logic                     mem_read_out,
  output logic                     mem_write_out,
  output logic [XLEN-1:0]          rs1_value_out,
  output logic [XLEN-1:0]          rs2_value_out,
  output logic [XLEN-1:0]          imm_value_out,
  output logic                     illegal_out
);

  localparam int RW = $clog2(NREGS);
  localparam logic [1:0] BUB_LOAD =
    (LOAD_USE_BUBBLES == 0) ? 2'd0 :
    2'(LOAD_USE_BUBBLES - 1);

  function automatic imm_fmt_e imm_fmt_of(
    input logic [6:0] op
  );
    imm_fmt_e f;
    unique case (1'b1)
      (op == I_TYPE_OP): f = IMM_I;
      (op == I_TYPE_LD): f = IMM_I;
      (op == S_TYPE):    f = IMM_S;
      (op == B_TYPE):    f = IMM_B;
      (op == U_TYPE):    f = IMM_U;
      (op == J_TYPE):    f = IMM_J;
      default:           f = IMM_NONE;
    endcase
    return f;
  endfunction

  function automatic logic [XLEN-1:0] imm_gen(
    input logic [31:0] i,
    input imm_fmt_e    f
  );
    logic [31:0] v;
    unique case (f)
      IMM_I: v = {{20{i[31]}}, i[31:20]};
      IMM_S: v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: v = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: v = {i[31:12], 12'b0};
      IMM_J: v = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return XLEN'($signed(v));
  endfunction

  logic           valid_q;
  logic [1:0]     bub_q;
  id_ex_payload_t pay_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [RW-1:0]  rd_q, rs1_idx_q, rs2_idx_q;

  logic [6:0]     opc;
  logic           known, use1, use2;
  logic           wr, ld, st, bad_idx, illegal;
  logic [RW-1:0]  rs1_idx, rs2_idx, rd_idx;
  id_ex_payload_t pay_d;
  logic [XLEN-1:0] imm_d, rs1_rd, rs2_rd;
  logic           hazard, accept;

  // Classify the incoming word; unused sources read x0.
  always_comb begin
    opc   = instr_in[6:0];
    known = 1'b1;
    use1  = 1'b0;
    use2  = 1'b0;
    wr    = 1'b0;
    ld    = 1'b0;
    st    = 1'b0;
    unique case (1'b1)
      (opc == R_TYPE): begin
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
      end
      (opc == I_TYPE_OP): begin
        use1 = 1'b1; wr = 1'b1;
      end
      (opc == I_TYPE_LD): begin
        use1 = 1'b1; wr = 1'b1; ld = 1'b1;
      end
      (opc == U_TYPE): wr = 1'b1;
      (opc == B_TYPE): begin
        use1 = 1'b1; use2 = 1'b1;
      end
      (opc == J_TYPE): wr = 1'b1;
      (opc == S_TYPE): begin
        use1 = 1'b1; use2 = 1'b1; st = 1'b1;
      end
      default: known = 1'b0;
    endcase
    bad_idx =
      (wr   && int'(instr_in[11:7])  >= NREGS) ||
      (use1 && int'(instr_in[19:15]) >= NREGS) ||
      (use2 && int'(instr_in[24:20]) >= NREGS);
    illegal = !known || bad_idx;
    rs1_idx = (use1 && !illegal) ?
              instr_in[15 +: RW] : '0;
    rs2_idx = (use2 && !illegal) ?
              instr_in[20 +: RW] : '0;
    rd_idx  = instr_in[7 +: RW];
    pay_d.alu_op    = opc;
    pay_d.funct3    = instr_in[14:12];
    pay_d.funct7    = instr_in[31:25];
    pay_d.rd_write  = wr && !illegal;
    pay_d.mem_read  = ld && !illegal;
    pay_d.mem_write = st && !illegal;
    pay_d.illegal   = illegal;
    imm_d = imm_gen(instr_in, imm_fmt_of(opc));
  end

  // Load-use check; idle fetch never causes a bubble.
  always_comb begin
    hazard = (LOAD_USE_BUBBLES != 0) &&
             in_valid && valid_q && ready_in &&
             pay_q.mem_read && rd_q != '0 &&
             (rs1_idx == rd_q || rs2_idx == rd_q);
    in_ready = (!valid_q || ready_in) &&
               bub_q == 2'd0 && !hazard && !flush;
    accept = in_valid && in_ready;
  end

  regfile_2r1w #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .WB_BYPASS (WB_BYPASS)
  ) u_rf (
    .clk    (req),
    .rst_n  (reset),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_rd),
    .rdata2 (rs2_rd),
    .we     (rd_write_in),
    .waddr  (rd_in),
    .wdata  (rd_value_in)
  );

  // Payload register: reset > flush > hazard > bubble > accept.
  always_ff @(posedge req) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      bub_q     <= 2'd0;
      pay_q     <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      bub_q   <= 2'd0;
    end else if (hazard) begin
      valid_q <= 1'b0;
      bub_q   <= BUB_LOAD;
    end else if (bub_q != 2'd0) begin
      valid_q <= 1'b0;
      bub_q   <= bub_q - 2'd1;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pay_q     <= pay_d;
      pc_q      <= pc_in_dec;
      rd_q      <= rd_idx;
      rs1_idx_q <= rs1_idx;
      rs2_idx_q <= rs2_idx;
      rs1_q     <= rs1_rd;
      rs2_q     <= rs2_rd;
      imm_q     <= imm_d;
    end else if (ready_in || !valid_q) begin
      valid_q <= 1'b0;
    end else if (rd_write_in && rd_in != '0) begin
      if (rd_in == rs1_idx_q) rs1_q <= rd_value_in;
      if (rd_in == rs2_idx_q) rs2_q <= rd_value_in;
    end
  end

  assign valid_out     = valid_q;
  assign pc_out_dec    = pc_q;
  assign funct3_out    = pay_q.funct3;
  assign funct7_out    = pay_q.funct7;
  assign alu_op_out    = pay_q.alu_op;
  assign rd_out        = rd_q;
  assign rd_write_out  = pay_q.rd_write;
  assign mem_read_out  = pay_q.mem_read;
  assign mem_write_out = pay_q.mem_write;
  assign rs1_value_out = rs1_q;
  assign rs2_value_out = rs2_q;
  assign imm_value_out = imm_q;
  assign illegal_out   = pay_q.illegal;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: spec-level model checked
// every cycle plus directed literal expectations.
module tb_decode_stage_p;

  localparam int LUB = 2;

  logic        req = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [31:0] instr_in, pc_in_dec;
  logic        flush;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] rd_value_in;
  logic        valid_out, ready_in;
  logic [31:0] pc_out_dec;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out, alu_op_out;
  logic [4:0]  rd_out;
  logic        rd_write_out, mem_read_out;
  logic        mem_write_out, illegal_out;
  logic [31:0] rs1_value_out, rs2_value_out;
  logic [31:0] imm_value_out;

  decode_stage_p #(
    .XLEN(32), .NREGS(32),
    .LOAD_USE_BUBBLES(LUB), .WB_BYPASS(1)
  ) dut (
    .req(req), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in_dec(pc_in_dec),
    .flush(flush), .rd_in(rd_in),
    .rd_write_in(rd_write_in),
    .rd_value_in(rd_value_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .pc_out_dec(pc_out_dec),
    .funct3_out(funct3_out),
    .funct7_out(funct7_out),
    .alu_op_out(alu_op_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out),
    .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out),
    .rs1_value_out(rs1_value_out),
    .rs2_value_out(rs2_value_out),
    .imm_value_out(imm_value_out),
    .illegal_out(illegal_out)
  );

  always #5 req = ~req;

  localparam logic [31:0] ADD8 = 32'h00528433;
  localparam logic [31:0] ADD4 = 32'h00318233;
  localparam logic [31:0] ADD6 = 32'h00038333;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] LUI  = 32'hABCDE0B7;
  localparam logic [31:0] ILL  = 32'h0000007F;
  localparam logic [31:0] LW   = 32'h0000A283;
  localparam logic [31:0] ADDI = 32'h00128313;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] imm;
    logic        wr, ld, st, ill;
    logic [4:0]  rs1, rs2;
  } dec_t;

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr, ld, st, ill;
  } exp_t;

  // Reference decode straight from the ISA tables.
  function automatic dec_t dec(input logic [31:0] i);
    dec_t d;
    logic [31:0] sx;
    d  = '0;
    sx = i[31] ? 32'hFFFFFFFF : 32'h0;
    case (i[6:0])
      7'h33: begin
        d.wr = 1; d.rs1 = i[19:15]; d.rs2 = i[24:20];
      end
      7'h13: begin
        d.wr = 1; d.rs1 = i[19:15];
        d.imm = $signed(i) >>> 20;
      end
      7'h03: begin
        d.wr = 1; d.ld = 1; d.rs1 = i[19:15];
        d.imm = $signed(i) >>> 20;
      end
      7'h37: begin
        d.wr = 1; d.imm = i & 32'hFFFFF000;
      end
      7'h63: begin
        d.rs1 = i[19:15]; d.rs2 = i[24:20];
        d.imm = (sx & 32'hFFFFF000) |
                (32'(i[7]) << 11) |
                (32'(i[30:25]) << 5) |
                (32'(i[11:8]) << 1);
      end
      7'h6F: begin
        d.wr = 1;
        d.imm = (sx & 32'hFFF00000) |
                (i & 32'h000FF000) |
                (32'(i[20]) << 11) |
                (32'(i[30:21]) << 1);
      end
      7'h23: begin
        d.st = 1; d.rs1 = i[19:15]; d.rs2 = i[24:20];
        d.imm = (($signed(i) >>> 20) & ~32'h1F) |
                32'(i[11:7]);
      end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  logic [31:0] mregs [32];
  exp_t        me;
  logic        mv;
  int          mbub;
  logic [4:0]  mrs1, mrs2;
  logic        armed = 1'b0;
  logic        last_rst = 1'b0;

  function automatic logic [31:0] rdv(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rd_write_in && rd_in == a) return rd_value_in;
    return mregs[a];
  endfunction

  function automatic logic m_hz();
    dec_t d;
    d = dec(instr_in);
    return in_valid && mv && ready_in && me.ld &&
           me.rd != 0 &&
           ((d.rs1 != 0 && d.rs1 == me.rd) ||
            (d.rs2 != 0 && d.rs2 == me.rd));
  endfunction

  function automatic logic m_rdy();
    return (!mv || ready_in) && mbub == 0 &&
           !m_hz() && !flush;
  endfunction

  task automatic step_model();
    dec_t d;
    logic hz, rdy;
    if (!reset) begin
      mv = 0; mbub = 0; mrs1 = 0; mrs2 = 0;
      me = '{default: '0};
      for (int k = 0; k < 32; k++) mregs[k] = 0;
      armed = 1; last_rst = 1;
      return;
    end
    last_rst = 0;
    d   = dec(instr_in);
    hz  = m_hz();
    rdy = m_rdy();
    if (flush) begin
      mv = 0; mbub = 0;
    end else if (hz) begin
      mv = 0; mbub = LUB - 1;
    end else if (mbub > 0) begin
      mbub--;
    end else if (in_valid && rdy) begin
      mv = 1;
      me.pc = pc_in_dec;
      me.op = instr_in[6:0];
      me.f3 = instr_in[14:12];
      me.f7 = instr_in[31:25];
      me.rd = instr_in[11:7];
      me.wr = d.wr; me.ld = d.ld;
      me.st = d.st; me.ill = d.ill;
      me.imm  = d.imm;
      me.rs1v = rdv(d.rs1);
      me.rs2v = rdv(d.rs2);
      mrs1 = d.rs1; mrs2 = d.rs2;
    end else if (ready_in || !mv) begin
      mv = 0;
    end else if (rd_write_in && rd_in != 0) begin
      if (rd_in == mrs1) me.rs1v = rd_value_in;
      if (rd_in == mrs2) me.rs2v = rd_value_in;
    end
    if (rd_write_in && rd_in != 0)
      mregs[rd_in] = rd_value_in;
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge req);
      step_model();
      #2;
      if (armed) begin
        chk("m_valid", valid_out, mv);
        chk("m_in_ready", in_ready, m_rdy());
        if (mv || last_rst) begin
          chk("m_pc", pc_out_dec, me.pc);
          chk("m_op", alu_op_out, me.op);
          chk("m_f3", funct3_out, me.f3);
          chk("m_f7", funct7_out, me.f7);
          chk("m_rd", rd_out, me.rd);
          chk("m_rdw", rd_write_out, me.wr);
          chk("m_mr", mem_read_out, me.ld);
          chk("m_mw", mem_write_out, me.st);
          chk("m_ill", illegal_out, me.ill);
          chk("m_rs1", rs1_value_out, me.rs1v);
          chk("m_rs2", rs2_value_out, me.rs2v);
          chk("m_imm", imm_value_out, me.imm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end

  task automatic drv(input logic [31:0] ins,
                     input logic [31:0] pc);
    in_valid = 1; instr_in = ins; pc_in_dec = pc;
  endtask

  task automatic wb(input logic [4:0] r,
                    input logic [31:0] v);
    rd_write_in = 1; rd_in = r; rd_value_in = v;
  endtask

  int bub;

  initial begin
    reset = 0; in_valid = 0; instr_in = 0;
    pc_in_dec = 0; flush = 0; rd_in = 0;
    rd_write_in = 0; rd_value_in = 0; ready_in = 1;
    repeat (2) @(negedge req);
    reset = 1;
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_imm", imm_value_out, 0);
    drv(ADD8, 32'h100);
    @(negedge req);
    chk("x5_zero", rs1_value_out, 0);
    drv(ADD4, 32'h104); wb(5'd3, 32'h1234);
    @(negedge req);
    chk("byp_rs1", rs1_value_out, 32'h1234);
    chk("byp_rs2", rs2_value_out, 32'h1234);
    rd_write_in = 0;
    drv(ADD6, 32'h108);
    @(negedge req);
    chk("bp_pc0", pc_out_dec, 32'h108);
    ready_in = 0; drv(BEQ, 32'h10C);
    wb(5'd7, 32'hBEEF);
    #1 chk("bp_ready0", in_ready, 0);
    @(negedge req);
    chk("bp_rs1", rs1_value_out, 32'hBEEF);
    chk("bp_pc", pc_out_dec, 32'h108);
    chk("bp_ready", in_ready, 0);
    chk("bp_valid", valid_out, 1);
    rd_write_in = 0; ready_in = 1;
    @(negedge req);
    chk("beq_imm", imm_value_out, 32'hFFFFFFFC);
    chk("beq_pc", pc_out_dec, 32'h10C);
    drv(LUI, 32'h110);
    @(negedge req);
    chk("lui_imm", imm_value_out, 32'hABCDE000);
    drv(ILL, 32'h114);
    @(negedge req);
    chk("ill_flag", illegal_out, 1);
    chk("ill_rdw", rd_write_out, 0);
    drv(LW, 32'h118);
    @(negedge req);
    chk("lw_mr", mem_read_out, 1);
    drv(ADDI, 32'h11C);
    #1 chk("lu_ready", in_ready, 0);
    @(negedge req);
    bub = 0;
    for (int k = 0; k < 8 && !valid_out; k++) begin
      bub++;
      if (k == 0) wb(5'd5, 32'h55);
      else rd_write_in = 0;
      @(negedge req);
    end
    rd_write_in = 0;
    chk("lu_bubbles", bub, 2);
    chk("lu_imm", imm_value_out, 1);
    chk("lu_rs1", rs1_value_out, 32'h55);
    chk("lu_pc", pc_out_dec, 32'h11C);
    drv(LW, 32'h120);
    @(negedge req);
    drv(ADDI, 32'h124);
    @(negedge req);
    chk("fl_bub_valid", valid_out, 0);
    flush = 1;
    @(negedge req);
    flush = 0; in_valid = 0;
    #1 chk("fl_ready", in_ready, 1);
    @(negedge req);
    chk("fl_no_issue", valid_out, 0);
    drv(ADDI, 32'h124);
    @(negedge req);
    chk("fl_reissue", valid_out, 1);
    chk("fl_pc", pc_out_dec, 32'h124);
    drv(LW, 32'h128);
    @(negedge req);
    drv(ADDI, 32'h12C);
    @(negedge req);
    reset = 0; in_valid = 0;
    @(negedge req);
    reset = 1;
    #1 chk("rs_ready", in_ready, 1);
    chk("rs_valid", valid_out, 0);
    drv(ADDI, 32'h12C);
    @(negedge req);
    chk("rs_issue", valid_out, 1);
    chk("rs_x5_clr", rs1_value_out, 0);
    in_valid = 0;
    repeat (3) @(negedge req);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
